burst_ram_responder: RTL and testbench

On-chip responder for the burst request interface the `mem_test` initiator drives. It services `wr_burst_*` and `rd_burst_*` transactions from a block-RAM array instead of the DDR3 MCB, so the initiator and debug probes can be brought up without external memory. It sits in place of `mem_ctrl`, clocked by `phy_clk`. It models configurable controller latency and a calibration phase.

---
 rtl/burst_ram_responder.sv | 181 ++++++++++++++++++
 tb/tb_burst_ram_responder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram_responder.sv
// Block-RAM stand-in for the DDR3 controller: services wr/rd burst requests
// from an on-chip array after an initial clear pass that models calibration.
module burst_ram_responder #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 24,
    parameter int MEM_AW      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  phy_clk,
    input  logic                  rst,
    output logic                  calib_done,
    input  logic                  wr_burst_req,
    input  logic [ADDR_WIDTH-1:0] wr_burst_addr,
    input  logic [9:0]            wr_burst_len,
    output logic                  wr_burst_data_req,
    input  logic [DATA_WIDTH-1:0] wr_burst_data,
    output logic                  wr_burst_finish,
    input  logic                  rd_burst_req,
    input  logic [ADDR_WIDTH-1:0] rd_burst_addr,
    input  logic [9:0]            rd_burst_len,
    output logic                  rd_burst_data_valid,
    output logic [DATA_WIDTH-1:0] rd_burst_data,
    output logic                  rd_burst_finish,
    output logic                  busy
);
    typedef enum logic [2:0] {
        INIT, IDLE, WR_WAIT, WR_DATA, WR_FIN, RD_WAIT, RD_DATA, RD_FIN
    } state_t;

    localparam logic       HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [7:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

    state_t              state_q, state_d;
    logic [7:0]          wait_q, wait_d;
    logic [9:0]          beat_q, beat_d;
    logic [9:0]          len_q, len_d;
    logic [MEM_AW-1:0]   base_q, base_d;
    logic [MEM_AW-1:0]   clr_q, clr_d;
    logic [MEM_AW-1:0]   widx_q, widx_d;
    logic                we_q, we_d;
    logic                calib_q, calib_d;
    logic                data_req_q, data_req_d;
    logic                wr_fin_q, wr_fin_d;
    logic                rd_fin_q, rd_fin_d;
    logic                rd_valid_q, rd_valid_d;
    logic                busy_q, busy_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                rd_en;
    logic                clr_we;
    logic [MEM_AW-1:0]   idx;

    logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

    // Burst index wraps naturally in MEM_AW bits.
    assign idx = base_q + MEM_AW'(beat_q);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        len_d   = len_q;
        base_d  = base_q;
        clr_d   = clr_q;
        widx_d  = widx_q;
        calib_d = calib_q;
        we_d    = 1'b0;
        rd_en   = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            INIT: begin
                clr_we = 1'b1;
                clr_d  = clr_q + 1'b1;
                if (clr_q == '1) begin
                    calib_d = 1'b1;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                wait_d = '0;
                beat_d = '0;
                if (wr_burst_req) begin
                    base_d  = wr_burst_addr[MEM_AW-1:0];
                    len_d   = wr_burst_len;
                    state_d = HAS_WAIT ? WR_WAIT : (wr_burst_len == '0 ? WR_FIN : WR_DATA);
                end else if (rd_burst_req) begin
                    base_d  = rd_burst_addr[MEM_AW-1:0];
                    len_d   = rd_burst_len;
                    state_d = HAS_WAIT ? RD_WAIT : (rd_burst_len == '0 ? RD_FIN : RD_DATA);
                end
            end
            WR_WAIT: begin
                wait_d = wait_q + 1'b1;
                if (wait_q == WAIT_LAST) state_d = (len_q == '0) ? WR_FIN : WR_DATA;
            end
            WR_DATA: begin
                we_d   = 1'b1;
                widx_d = idx;
                beat_d = beat_q + 1'b1;
                if (beat_q == len_q - 10'd1) state_d = WR_FIN;
            end
            RD_WAIT: begin
                wait_d = wait_q + 1'b1;
                if (wait_q == WAIT_LAST) state_d = (len_q == '0) ? RD_FIN : RD_DATA;
            end
            RD_DATA: begin
                // One extra cycle after the last issue lets the final word drain.
                rd_en  = (beat_q != len_q);
                beat_d = beat_q + 1'b1;
                if (beat_q == len_q) state_d = RD_FIN;
            end
            WR_FIN, RD_FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        data_req_d = (state_d == WR_DATA);
        wr_fin_d   = (state_d == WR_FIN);
        rd_fin_d   = (state_d == RD_FIN);
        busy_d     = (state_d != IDLE);
        rd_valid_d = rd_en;
    end

    always_ff @(posedge phy_clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            wait_q     <= '0;
            beat_q     <= '0;
            len_q      <= '0;
            base_q     <= '0;
            clr_q      <= '0;
            widx_q     <= '0;
            we_q       <= 1'b0;
            calib_q    <= 1'b0;
            data_req_q <= 1'b0;
            wr_fin_q   <= 1'b0;
            rd_fin_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            base_q     <= base_d;
            clr_q      <= clr_d;
            widx_q     <= widx_d;
            we_q       <= we_d;
            calib_q    <= calib_d;
            data_req_q <= data_req_d;
            wr_fin_q   <= wr_fin_d;
            rd_fin_q   <= rd_fin_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge phy_clk) begin
        if (clr_we) mem[clr_q] <= '0;
        else if (we_q) mem[widx_q] <= wr_burst_data;
    end

    always_ff @(posedge phy_clk or posedge rst) begin
        if (rst) rd_data_q <= '0;
        else if (rd_en) rd_data_q <= mem[idx];
    end

    generate
        if (ADDR_WIDTH > MEM_AW) begin : g_unused
            logic unused_addr_bits;
            assign unused_addr_bits = ^{wr_burst_addr[ADDR_WIDTH-1:MEM_AW],
                                        rd_burst_addr[ADDR_WIDTH-1:MEM_AW]};
        end
    endgenerate

    assign calib_done          = calib_q;
    assign wr_burst_data_req   = data_req_q;
    assign wr_burst_finish     = wr_fin_q;
    assign rd_burst_finish     = rd_fin_q;
    assign rd_burst_data_valid = rd_valid_q;
    assign rd_burst_data       = rd_data_q;
    assign busy                = busy_q;
endmodule

// File: tb/tb_burst_ram_responder.sv
// Bench for burst_ram_responder: two instances (WAIT_CYCLES 0 and 3), a RAM
// model per instance, and a read-data scoreboard popped on every valid beat.
module tb_burst_ram_responder;
    logic        phy_clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_req [2], rd_req [2], data_req [2], wr_fin [2];
    logic        rd_valid [2], rd_fin [2], calib [2], busy [2];
    logic [23:0] wr_addr [2], rd_addr [2];
    logic [9:0]  wr_len [2], rd_len [2];
    logic [63:0] wr_data [2], rd_data [2];

    logic [63:0] model [2][1024];
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 phy_clk = ~phy_clk;
    always @(posedge phy_clk) cyc <= cyc + 1;

    burst_ram_responder #(.WAIT_CYCLES(0)) u_w0 (
        .phy_clk(phy_clk), .rst(rst), .calib_done(calib[0]),
        .wr_burst_req(wr_req[0]), .wr_burst_addr(wr_addr[0]), .wr_burst_len(wr_len[0]),
        .wr_burst_data_req(data_req[0]), .wr_burst_data(wr_data[0]), .wr_burst_finish(wr_fin[0]),
        .rd_burst_req(rd_req[0]), .rd_burst_addr(rd_addr[0]), .rd_burst_len(rd_len[0]),
        .rd_burst_data_valid(rd_valid[0]), .rd_burst_data(rd_data[0]), .rd_burst_finish(rd_fin[0]),
        .busy(busy[0]));

    burst_ram_responder #(.WAIT_CYCLES(3)) u_w3 (
        .phy_clk(phy_clk), .rst(rst), .calib_done(calib[1]),
        .wr_burst_req(wr_req[1]), .wr_burst_addr(wr_addr[1]), .wr_burst_len(wr_len[1]),
        .wr_burst_data_req(data_req[1]), .wr_burst_data(wr_data[1]), .wr_burst_finish(wr_fin[1]),
        .rd_burst_req(rd_req[1]), .rd_burst_addr(rd_addr[1]), .rd_burst_len(rd_len[1]),
        .rd_burst_data_valid(rd_valid[1]), .rd_burst_data(rd_data[1]), .rd_burst_finish(rd_fin[1]),
        .busy(busy[1]));

    function automatic void push(input int d, input logic [63:0] v);
        if (d == 0) q0.push_back(v);
        else q1.push_back(v);
    endfunction

    // Scoreboard: every valid beat must match the oldest expected word.
    always @(negedge phy_clk) begin
        logic [63:0] e;
        if (!rst && rd_valid[0]) begin
            vectors++;
            if (q0.size() == 0) begin
                miscompares++;
                $display("FAIL rd_data d0: got unexpected beat %h, want none", rd_data[0]);
            end else begin
                e = q0.pop_front();
                if (rd_data[0] !== e) begin
                    miscompares++;
                    $display("FAIL rd_data d0 cyc %0d: got %h want %h", cyc, rd_data[0], e);
                end
            end
        end
        if (!rst && rd_valid[1]) begin
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL rd_data d1: got unexpected beat %h, want none", rd_data[1]);
            end else begin
                e = q1.pop_front();
                if (rd_data[1] !== e) begin
                    miscompares++;
                    $display("FAIL rd_data d1 cyc %0d: got %h want %h", cyc, rd_data[1], e);
                end
            end
        end
    end

    task automatic do_write(input int d, input int addr, input int len, input logic [63:0] base);
        int t0, k, w;
        bit pend, seen;
        logic e;
        w = (d == 0) ? 0 : 3;
        for (int i = 0; i < len; i++) model[d][(addr + i) % 1024] = base + 64'(i);
        @(negedge phy_clk);
        wr_req[d] = 1'b1; wr_addr[d] = 24'(addr); wr_len[d] = 10'(len); t0 = cyc;
        k = 0; pend = 0; seen = 0;
        for (int n = 0; n < w + len + 8 && !seen; n++) begin
            @(negedge phy_clk);
            if (pend) begin wr_data[d] = base + 64'(k); k++; end
            pend = data_req[d];
            e = (cyc >= t0 + w + 1 && cyc <= t0 + w + len);
            vectors++;
            if (data_req[d] !== e) begin
                miscompares++;
                $display("FAIL wr_data_req d%0d T0+%0d: got %b want %b", d, cyc - t0, data_req[d], e);
            end
            e = (cyc == t0 + w + len + 1);
            vectors++;
            if (wr_fin[d] !== e) begin
                miscompares++;
                $display("FAIL wr_finish d%0d T0+%0d: got %b want %b", d, cyc - t0, wr_fin[d], e);
            end
            if (wr_fin[d]) begin seen = 1; wr_req[d] = 1'b0; end
        end
        if (!seen) begin
            miscompares++; wr_req[d] = 1'b0;
            $display("FAIL wr_finish d%0d timeout: got none want pulse", d);
        end
    endtask

    task automatic do_read(input int d, input int addr, input int len);
        int t0, w, fin_t, sz;
        bit seen;
        logic e;
        w = (d == 0) ? 0 : 3;
        for (int i = 0; i < len; i++) push(d, model[d][(addr + i) % 1024]);
        @(negedge phy_clk);
        rd_req[d] = 1'b1; rd_addr[d] = 24'(addr); rd_len[d] = 10'(len); t0 = cyc;
        fin_t = (len == 0) ? t0 + w + 1 : t0 + w + len + 2;
        seen = 0;
        for (int n = 0; n < w + len + 8 && !seen; n++) begin
            @(negedge phy_clk);
            e = (cyc >= t0 + w + 2 && cyc <= t0 + w + len + 1);
            vectors++;
            if (rd_valid[d] !== e) begin
                miscompares++;
                $display("FAIL rd_valid d%0d T0+%0d: got %b want %b", d, cyc - t0, rd_valid[d], e);
            end
            e = (cyc == fin_t);
            vectors++;
            if (rd_fin[d] !== e) begin
                miscompares++;
                $display("FAIL rd_finish d%0d T0+%0d: got %b want %b", d, cyc - t0, rd_fin[d], e);
            end
            if (rd_fin[d]) begin seen = 1; rd_req[d] = 1'b0; end
        end
        if (!seen) begin
            miscompares++; rd_req[d] = 1'b0;
            $display("FAIL rd_finish d%0d timeout: got none want pulse", d);
        end
        sz = (d == 0) ? q0.size() : q1.size();
        vectors++;
        if (sz != 0) begin
            miscompares++;
            $display("FAIL rd_beats d%0d: got %0d words missing want 0", d, sz);
        end
    endtask

    task automatic test_reset;
        int r;
        bit bad;
        repeat (3) @(negedge phy_clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({calib[d], busy[d], data_req[d], wr_fin[d], rd_valid[d], rd_fin[d]} !== 6'b010000 ||
                rd_data[d] !== 64'h0) begin
                miscompares++;
                $display("FAIL reset_outputs d%0d: got %b%b%b%b%b%b/%h want 010000/0", d, calib[d],
                         busy[d], data_req[d], wr_fin[d], rd_valid[d], rd_fin[d], rd_data[d]);
            end
        end
        // A write held through INIT must be ignored until calibration is done.
        wr_req[0] = 1'b1; wr_addr[0] = 24'h0; wr_len[0] = 10'd4;
        rst = 1'b0; r = cyc; bad = 0;
        for (int n = 0; n < 1024; n++) begin
            @(negedge phy_clk);
            if (data_req[0]) bad = 1;
            if (cyc == r + 1023) begin
                wr_req[0] = 1'b0;
                vectors++;
                if (calib[0] !== 1'b0 || calib[1] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL calib_early: got %b%b want 00 at +1023", calib[0], calib[1]);
                end
            end
        end
        vectors++;
        if (calib[0] !== 1'b1 || calib[1] !== 1'b1 || busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL calib_rise: got calib %b%b busy %b want 11 busy 0 at +1024",
                     calib[0], calib[1], busy[0]);
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL init_ignore_req: got data_req during INIT want none");
        end
    endtask

    task automatic test_write_read;
        do_write(0, 'h10, 4, 64'hA0);
        do_read(0, 'h10, 4);
    endtask

    task automatic test_wrap;
        do_write(1, 'h123FE, 3, 64'hD0);
        do_read(1, 'h3FE, 3);
        do_read(1, 'h0, 1);
    endtask

    task automatic test_arbitration;
        int t0, tw, k;
        bit pend, done;
        logic e;
        for (int i = 0; i < 2; i++) model[0][64 + i] = 64'hB0 + 64'(i);
        push(0, model[0][64]); push(0, model[0][65]);
        @(negedge phy_clk);
        wr_req[0] = 1'b1; wr_addr[0] = 24'h40; wr_len[0] = 10'd2;
        rd_req[0] = 1'b1; rd_addr[0] = 24'h40; rd_len[0] = 10'd2;
        t0 = cyc; tw = -100; k = 0; pend = 0; done = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge phy_clk);
            if (pend) begin wr_data[0] = 64'hB0 + 64'(k); k++; end
            pend = data_req[0];
            if (wr_fin[0]) begin
                tw = cyc; wr_req[0] = 1'b0;
                vectors++;
                if (cyc != t0 + 3) begin
                    miscompares++;
                    $display("FAIL arb_wr_finish: got T0+%0d want T0+3", cyc - t0);
                end
            end
            e = (cyc >= tw + 3 && cyc <= tw + 4);
            vectors++;
            if (rd_valid[0] !== e) begin
                miscompares++;
                $display("FAIL arb_rd_valid T0+%0d: got %b want %b", cyc - t0, rd_valid[0], e);
            end
            if (rd_fin[0]) begin
                done = 1; rd_req[0] = 1'b0;
                vectors++;
                if (cyc != tw + 5) begin
                    miscompares++;
                    $display("FAIL arb_rd_finish: got T0+%0d want T0+%0d", cyc - t0, tw + 5 - t0);
                end
            end
        end
        if (!done) begin
            miscompares++; wr_req[0] = 1'b0; rd_req[0] = 1'b0;
            $display("FAIL arb_timeout: got no rd_finish want pulse");
        end
    endtask

    task automatic test_len0_unwritten;
        do_read(0, 'h200, 0);
        do_read(0, 'h300, 2);
    endtask

    task automatic test_reset_mid_burst;
        int beats;
        bit fin_seen, up;
        do_write(0, 'h80, 8, 64'hC0);
        push(0, model[0][128]); push(0, model[0][129]);
        @(negedge phy_clk);
        rd_req[0] = 1'b1; rd_addr[0] = 24'h80; rd_len[0] = 10'd8;
        beats = 0;
        for (int n = 0; n < 20 && beats < 2; n++) begin
            @(negedge phy_clk);
            if (rd_valid[0]) beats++;
        end
        vectors++;
        if (beats < 2) begin
            miscompares++;
            $display("FAIL midrst_beats: got %0d want 2", beats);
        end
        #2 rst = 1'b1; rd_req[0] = 1'b0;
        #1;
        vectors++;
        if ({calib[0], busy[0], rd_valid[0], rd_fin[0], data_req[0]} !== 5'b01000 || rd_data[0] !== 64'h0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got %b%b%b%b%b/%h want 01000/0", calib[0], busy[0],
                     rd_valid[0], rd_fin[0], data_req[0], rd_data[0]);
        end
        q0.delete(); q1.delete();
        for (int d = 0; d < 2; d++) for (int i = 0; i < 1024; i++) model[d][i] = 64'h0;
        repeat (2) @(negedge phy_clk);
        rst = 1'b0;
        fin_seen = 0; up = 0;
        for (int n = 0; n < 1100 && !up; n++) begin
            @(negedge phy_clk);
            if (rd_fin[0] || wr_fin[0]) fin_seen = 1;
            up = calib[0] && calib[1];
        end
        vectors++;
        if (!up || fin_seen) begin
            miscompares++;
            $display("FAIL midrst_recal: got calib_up %b finish_seen %b want 1 0", up, fin_seen);
        end
        do_read(0, 'h80, 2);
        do_read(1, 'h3FE, 1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            wr_req[d] = 1'b0; rd_req[d] = 1'b0;
            wr_addr[d] = '0; rd_addr[d] = '0; wr_len[d] = '0; rd_len[d] = '0;
            wr_data[d] = '0;
            for (int i = 0; i < 1024; i++) model[d][i] = 64'h0;
        end
        test_reset;
        test_write_read;
        test_wrap;
        test_arbitration;
        test_len0_unwritten;
        test_reset_mid_burst;
        repeat (2) @(negedge phy_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
